tile_move_ctrl: RTL

TILE_MOVE_CTRL -- requirements
Module: tile_move_ctrl

---
 rtl/tile_pkg.sv | 26 ++
 rtl/axis_stepper.sv | 44 ++++
 rtl/tile_move_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared grid geometry and FSM state type for the tile mover.
// Grid cells are PITCH apart; tiles are TILE_SIZE square.
package tile_pkg;

  localparam int GRID_N    = 4;
  localparam int X0        = 40;
  localparam int Y0        = 40;
  localparam int PITCH     = 100;
  localparam int TILE_SIZE = 94;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE,
    DONE
  } state_t;

  function automatic logic [10:0] cell_px(
    input logic [10:0] org,
    input logic [10:0] pitch,
    input logic [1:0]  idx
  );
    return org + pitch * 11'(idx);
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One axis of tile motion: saturating step of an 11-bit
// position toward a latched target, with an arrival flag.
module axis_stepper #(
  parameter int STEP    = 10,
  parameter int RST_POS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [10:0] load_pos,
  input  logic [10:0] load_tgt,
  input  logic        step,
  output logic [10:0] pos,
  output logic        at
);

  localparam logic [10:0] STEP_L = 11'(STEP);

  logic [10:0] tgt;
  logic [10:0] diff;
  logic [10:0] amt;
  logic        up;

  always_comb begin
    up   = pos < tgt;
    diff = up ? tgt - pos : pos - tgt;
    amt  = (diff > STEP_L) ? STEP_L : diff;
  end

  assign at = (pos == tgt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= 11'(RST_POS);
      tgt <= '0;
    end else if (load) begin
      pos <= load_pos;
      tgt <= load_tgt;
    end else if (step) begin
      pos <= up ? pos + amt : pos - amt;
    end
  end

endmodule

// File: rtl/tile_move_ctrl.sv
// Animates one tile between grid cells on frame ticks, then
// highlights it for HOLD_FRAMES ticks and pulses done.
module tile_move_ctrl
  import tile_pkg::*;
#(
  parameter int X0          = tile_pkg::X0,
  parameter int Y0          = tile_pkg::Y0,
  parameter int PITCH       = tile_pkg::PITCH,
  parameter int STEP        = 10,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [1:0]  src_row,
  input  logic [1:0]  src_col,
  input  logic [1:0]  dst_row,
  input  logic [1:0]  dst_col,
  output logic [10:0] ix,
  output logic [10:0] iy,
  output logic        on,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] X0_L = 11'(X0);
  localparam logic [10:0] Y0_L = 11'(Y0);
  localparam logic [10:0] PT_L = 11'(PITCH);
  localparam int          HW   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_t      state;
  logic [HW-1:0] hold_cnt;
  logic        load;
  logic        step;
  logic        at_x;
  logic        at_y;
  logic        same;
  logic [10:0] sx, sy, tx, ty;

  assign sx   = cell_px(X0_L, PT_L, src_col);
  assign sy   = cell_px(Y0_L, PT_L, src_row);
  assign tx   = cell_px(X0_L, PT_L, dst_col);
  assign ty   = cell_px(Y0_L, PT_L, dst_row);
  assign same = (src_row == dst_row) && (src_col == dst_col);
  assign load = start && (state == IDLE);
  assign step = frame_tick && (state == MOVE);

  axis_stepper #(.STEP(STEP), .RST_POS(X0)) u_x (
    .clk      (pixel_clk),
    .rst      (rst),
    .load     (load),
    .load_pos (sx),
    .load_tgt (tx),
    .step     (step),
    .pos      (ix),
    .at       (at_x)
  );

  axis_stepper #(.STEP(STEP), .RST_POS(Y0)) u_y (
    .clk      (pixel_clk),
    .rst      (rst),
    .load     (load),
    .load_pos (sy),
    .load_tgt (ty),
    .step     (step),
    .pos      (iy),
    .at       (at_y)
  );

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state    <= IDLE;
      on       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (same) begin
            state <= SETTLE;
            on    <= 1'b1;
          end else begin
            state <= MOVE;
          end
        end
        MOVE: if (at_x && at_y) begin
          state <= SETTLE;
          on    <= 1'b1;
        end
        SETTLE: if (frame_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= DONE;
            on       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
